// File: rtl/boot_rom_ctrl_if.sv
// Request/response bus between a fetch master and boot_rom_ctrl.
// Master drives req_i/addr_i/we_i; slave returns gnt_o/rvalid_o/rdata_o/err_o.
// Signal names carry the direction as seen from the controller.
interface boot_rom_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic [31:0]           addr_i;
  logic                  we_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport master (
    output req_i, addr_i, we_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/boot_rom_ctrl.sv
// Boot ROM front end with a small lockable word-patch table overriding ROM words.
// Latency: fixed LATENCY cycles request-to-rvalid, in order, one request per cycle.
// Backpressure: none; gnt_o mirrors req_i and the pipeline never stalls.
// Ports: clk_i/rst_ni (sync active-low), bus (request/response), rom_* (ROM macro),
//        cfg_* (patch table write + lock), locked_o (sticky lock state).
module boot_rom_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,   // 32 or 64
  parameter int LATENCY    = 1,    // 1..3
  parameter int N_PATCH    = 4,    // 1..16
  localparam int WOFF = $clog2(DATA_WIDTH/8),
  localparam int AW   = ADDR_WIDTH - WOFF,
  localparam int IDXW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  boot_rom_ctrl_if.slave        bus,
  output logic                  rom_csn_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  input  logic                  cfg_we_i,
  input  logic [IDXW-1:0]       cfg_idx_i,
  input  logic [AW-1:0]         cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_lock_i,
  output logic                  locked_o
);

  // Patch table
  logic [N_PATCH-1:0]    pt_en_q, pt_en_d;
  logic [AW-1:0]         pt_addr_q [N_PATCH];
  logic [AW-1:0]         pt_addr_d [N_PATCH];
  logic [DATA_WIDTH-1:0] pt_data_q [N_PATCH];
  logic [DATA_WIDTH-1:0] pt_data_d [N_PATCH];
  logic                  locked_q, locked_d;

  // Response pipeline; stage 0 holds the accepted request, the last stage drives the bus
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [LATENCY-1:0]    err_q, err_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_d [LATENCY];

  // Request decode
  logic                  in_range, legal, hit;
  logic [AW-1:0]         word_addr;
  logic [DATA_WIDTH-1:0] hit_data, res_data, out_data;
  logic                  out_vld;

  // Byte-lane bits are don't-care for word fetches.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr_i[WOFF-1:0];

  always_comb begin
    word_addr = bus.addr_i[ADDR_WIDTH-1:WOFF];
    in_range  = (bus.addr_i[31:ADDR_WIDTH] == '0);
    legal     = bus.req_i && in_range && !bus.we_i;
    hit       = 1'b0;
    hit_data  = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    // Uses the _q table, so a same-cycle cfg write cannot affect this lookup.
    for (int i = N_PATCH-1; i >= 0; i--) begin
      if (pt_en_q[i] && (pt_addr_q[i] == word_addr)) begin
        hit      = 1'b1;
        hit_data = pt_data_q[i];
      end
    end
  end

  assign bus.gnt_o  = bus.req_i;
  assign rom_csn_o  = !(legal && rst_ni);
  assign rom_addr_o = word_addr;

  // Patch table / lock next state. A write alongside the lock request still lands
  // because the gate looks at the current lock state, not the next one.
  always_comb begin
    pt_en_d   = pt_en_q;
    pt_addr_d = pt_addr_q;
    pt_data_d = pt_data_q;
    locked_d  = locked_q | cfg_lock_i;
    if (cfg_we_i && !locked_q) begin
      // Out-of-range indices simply match no entry.
      for (int i = 0; i < N_PATCH; i++) begin
        if (cfg_idx_i == IDXW'(i)) begin
          pt_en_d[i]   = cfg_en_i;
          pt_addr_d[i] = cfg_addr_i;
          pt_data_d[i] = cfg_data_i;
        end
      end
    end
  end

  // Pipeline next state. ROM data arrives in the cycle after acceptance, which is
  // when stage 0 is live; it is resolved against hit/err there.
  always_comb begin
    vld_d[0]  = bus.req_i;
    err_d[0]  = bus.req_i && !legal;
    hit_d     = legal && hit;
    data_d[0] = hit_data;
    res_data  = err_q[0] ? '0 : (hit_q ? data_q[0] : rom_rdata_i);
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      err_d[k]  = err_q[k-1];
      data_d[k] = (k == 1) ? res_data : data_q[k-1];
    end
  end

  // Outputs are forced quiet while reset is held, even before the clearing edge.
  always_comb begin
    out_vld      = vld_q[LATENCY-1] && rst_ni;
    out_data     = (LATENCY == 1) ? res_data : data_q[LATENCY-1];
    bus.rvalid_o = out_vld;
    bus.err_o    = out_vld && err_q[LATENCY-1];
    bus.rdata_o  = out_vld ? out_data : '0;
  end

  assign locked_o = locked_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      pt_en_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      pt_en_q  <= pt_en_d;
      locked_q <= locked_d;
    end
  end

  // Payload state needs no reset: it is only observed when qualified by a valid/enable.
  always_ff @(posedge clk_i) begin
    err_q     <= err_d;
    hit_q     <= hit_d;
    data_q    <= data_d;
    pt_addr_q <= pt_addr_d;
    pt_data_q <= pt_data_d;
  end

endmodule

// File: tb/tb_boot_rom_ctrl.sv
module tb_boot_rom_ctrl;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared cfg stimulus
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [10:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_lock = 1'b0;

  boot_rom_ctrl_if #(.DATA_WIDTH(32)) bus1 ();
  boot_rom_ctrl_if #(.DATA_WIDTH(32)) bus3 ();

  logic        csn1, csn3, lk1, lk3;
  logic [10:0] ra1, ra3;
  logic [31:0] rd1 = '0;
  logic [31:0] rd3 = '0;

  boot_rom_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .LATENCY(1), .N_PATCH(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus1),
    .rom_csn_o(csn1), .rom_addr_o(ra1), .rom_rdata_i(rd1),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_en_i(cfg_en), .cfg_lock_i(cfg_lock),
    .locked_o(lk1)
  );

  boot_rom_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .LATENCY(3), .N_PATCH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus3),
    .rom_csn_o(csn3), .rom_addr_o(ra3), .rom_rdata_i(rd3),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_en_i(cfg_en), .cfg_lock_i(cfg_lock),
    .locked_o(lk3)
  );

  // ROM: word 0x10 holds DEADBEEF, every other word w holds 0x1000_0000|w.
  // An unselected cycle returns garbage so a missing chip select shows up.
  function automatic logic [31:0] rom_word(input logic [10:0] w);
    return (w == 11'h010) ? 32'hDEADBEEF : (32'h1000_0000 | {21'b0, w});
  endfunction

  always @(posedge clk) rd1 <= csn1 ? 32'hBAD0BAD0 : rom_word(ra1);
  always @(posedge clk) rd3 <= csn3 ? 32'hBAD0BAD0 : rom_word(ra3);

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the LATENCY=1 instance
  always @(negedge clk) begin
    if (bus1.rvalid_o) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL l1_unexpected_rvalid: rvalid=1 with no response pending (rdata=%0h cycle %0d)",
                 bus1.rdata_o, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("l1_rdata", 64'(bus1.rdata_o), 64'(e1.data));
        chk("l1_err",   64'(bus1.err_o),   64'(e1.err));
        chk("l1_cycle", 64'(cyc),          64'(e1.due));
      end
    end else begin
      chk("l1_idle_quiet", 64'({bus1.err_o, bus1.rdata_o}), 64'd0);
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        e1 = q1.pop_front();
        n_chk++; n_fail++;
        $display("FAIL l1_missing_rvalid: rvalid=0, expected response %0h due at cycle %0d",
                 e1.data, e1.due);
      end
    end
  end

  // Monitor for the LATENCY=3 instance
  always @(negedge clk) begin
    if (bus3.rvalid_o) begin
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL l3_unexpected_rvalid: rvalid=1 with no response pending (rdata=%0h cycle %0d)",
                 bus3.rdata_o, cyc);
      end else begin
        e3 = q3.pop_front();
        chk("l3_rdata", 64'(bus3.rdata_o), 64'(e3.data));
        chk("l3_err",   64'(bus3.err_o),   64'(e3.err));
        chk("l3_cycle", 64'(cyc),          64'(e3.due));
      end
    end else begin
      chk("l3_idle_quiet", 64'({bus3.err_o, bus3.rdata_o}), 64'd0);
      if (q3.size() > 0 && q3[0].due <= cyc) begin
        e3 = q3.pop_front();
        n_chk++; n_fail++;
        $display("FAIL l3_missing_rvalid: rvalid=0, expected response %0h due at cycle %0d",
                 e3.data, e3.due);
      end
    end
  end

  // Reset drops anything that would have come out in this cycle or later.
  task automatic set_rst(input logic v);
    rst_ni = v;
    if (!v) begin
      while (q1.size() > 0 && q1[$].due >= cyc) void'(q1.pop_back());
      while (q3.size() > 0 && q3[$].due >= cyc) void'(q3.pop_back());
    end
  endtask

  // One cycle: present request + cfg, check same-cycle outputs, queue the response.
  task automatic cyc_op(input logic req, input logic [31:0] addr, input logic we,
                        input logic cwe, input logic [1:0] cidx, input logic [10:0] caddr,
                        input logic [31:0] cdata, input logic cen, input logic lock,
                        input logic [31:0] edata, input logic eerr);
    logic legal;
    exp_t e;
    bus1.req_i = req; bus1.addr_i = addr; bus1.we_i = we;
    bus3.req_i = req; bus3.addr_i = addr; bus3.we_i = we;
    cfg_we = cwe; cfg_idx = cidx; cfg_addr = caddr;
    cfg_data = cdata; cfg_en = cen; cfg_lock = lock;
    #1;
    legal = req && !eerr && rst_ni;
    chk("gnt", 64'({bus1.gnt_o, bus3.gnt_o}), 64'({req, req}));
    chk("rom_csn", 64'({csn1, csn3}), 64'({!legal, !legal}));
    if (legal) chk("rom_addr", 64'({ra1, ra3}), 64'({addr[12:2], addr[12:2]}));
    if (req && rst_ni) begin
      e.data = edata; e.err = eerr;
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
    end
    @(posedge clk); #1;
    bus1.req_i = 1'b0; bus3.req_i = 1'b0;
    bus1.we_i = 1'b0; bus3.we_i = 1'b0;
    cfg_we = 1'b0; cfg_lock = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] edata);
    cyc_op(1'b1, addr, 1'b0, 1'b0, 2'd0, 11'd0, 32'd0, 1'b0, 1'b0, edata, 1'b0);
  endtask

  task automatic bad(input logic [31:0] addr, input logic we);
    cyc_op(1'b1, addr, we, 1'b0, 2'd0, 11'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [10:0] a, input logic [31:0] d,
                     input logic en, input logic lock);
    cyc_op(1'b0, 32'd0, 1'b0, 1'b1, idx, a, d, en, lock, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc_op(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 11'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    bus1.req_i = 1'b0; bus1.addr_i = '0; bus1.we_i = 1'b0;
    bus3.req_i = 1'b0; bus3.addr_i = '0; bus3.we_i = 1'b0;
    @(posedge clk); #1;

    // Reset: requests are ignored, chip select stays high, lock clear
    set_rst(1'b0);
    rd(32'h40, 32'h0);
    idle(2);
    chk("locked_in_reset", 64'({lk1, lk3}), 64'd0);
    set_rst(1'b1);
    idle(1);

    // Plain ROM reads, back to back, byte offset ignored, top word of the window
    rd(32'h40, 32'hDEADBEEF);
    rd(32'h44, 32'h10000011);
    rd(32'h43, 32'hDEADBEEF);
    rd(32'h1FFC, 32'h100007FF);

    // Out of range and write attempts
    bad(32'h2000, 1'b0);
    bad(32'h0, 1'b1);
    bad(32'hFFFFFFFC, 1'b0);

    // Patch idx0 with a read in the same cycle: lookup sees the old table
    cyc_op(1'b1, 32'h40, 1'b0, 1'b1, 2'd0, 11'h010, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    rd(32'h40, 32'h12345678);
    // idx2 on the same word: lowest index still wins
    cfg(2'd2, 11'h010, 32'hCAFEF00D, 1'b1, 1'b0);
    rd(32'h40, 32'h12345678);
    // Disable idx0: idx2 takes over
    cfg(2'd0, 11'h010, 32'h0, 1'b0, 1'b0);
    rd(32'h40, 32'hCAFEF00D);
    // Index 3 is beyond N_PATCH=3 and must be ignored
    cfg(2'd3, 11'h011, 32'h55, 1'b1, 1'b0);
    rd(32'h44, 32'h10000011);
    // Write to a patched word still errors
    bad(32'h40, 1'b1);

    // Lock together with a write: write lands, later writes do not
    chk("locked_before", 64'({lk1, lk3}), 64'd0);
    cfg(2'd1, 11'h012, 32'h0BADF00D, 1'b1, 1'b1);
    chk("locked_set", 64'({lk1, lk3}), 64'h3);
    rd(32'h48, 32'h0BADF00D);
    cfg(2'd1, 11'h013, 32'h77777777, 1'b1, 1'b0);
    rd(32'h4C, 32'h10000013);
    rd(32'h48, 32'h0BADF00D);
    cfg(2'd2, 11'h010, 32'h0, 1'b0, 1'b0);
    rd(32'h40, 32'hCAFEF00D);
    chk("locked_sticky", 64'({lk1, lk3}), 64'h3);

    // Reset clears lock and all enables
    set_rst(1'b0);
    idle(2);
    set_rst(1'b1);
    chk("locked_after_reset", 64'({lk1, lk3}), 64'd0);
    rd(32'h40, 32'hDEADBEEF);
    rd(32'h48, 32'h10000012);
    idle(4);

    // Four back-to-back reads, then reset at T+4 drops everything not yet out
    rd(32'h40, 32'hDEADBEEF);
    rd(32'h44, 32'h10000011);
    rd(32'h48, 32'h10000012);
    rd(32'h4C, 32'h10000013);
    set_rst(1'b0);
    idle(3);
    set_rst(1'b1);
    rd(32'h44, 32'h10000011);
    idle(6);

    chk("l1_drained", 64'(q1.size()), 64'd0);
    chk("l3_drained", 64'(q3.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
